// File: rtl/shift_right_pipe.sv
// shift_right_pipe: four-stage valid/ready right shifter/rotator, one power-of-two shift per stage
module shift_right_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic [1:0]  Op,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] Out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  occ
);
  logic        v0_q, v1_q, v2_q, v3_q;
  logic [15:0] d0_q, d1_q, d2_q, d3_q;
  logic [15:0] d0_d, d1_d, d2_d, d3_d;
  logic [3:1]  c0_q;
  logic [3:2]  c1_q;
  logic        c2_q;
  logic [1:0]  op0_q, op1_q, op2_q;
  logic        f0_q, f1_q, f2_q;
  logic        rdy0, rdy1, rdy2, rdy3;

  // Each stage keeps only the count bits still needed downstream.
  function automatic logic [15:0] stage_f(input logic [15:0] d, input logic en,
                                          input logic [1:0] op, input logic fill, input int sh);
    logic [15:0] fw;
    fw = op == 2'b10 ? d : op == 2'b01 ? {16{fill}} : 16'h0;
    return (en && op != 2'b00) ? (d >> sh) | (fw << (16 - sh)) : d;
  endfunction

  assign d0_d = stage_f(In,   Cnt[0],  Op,    In[15], 1);
  assign d1_d = stage_f(d0_q, c0_q[1], op0_q, f0_q,   2);
  assign d2_d = stage_f(d1_q, c1_q[2], op1_q, f1_q,   4);
  assign d3_d = stage_f(d2_q, c2_q,    op2_q, f2_q,   8);

  assign rdy3      = !v3_q | out_ready;
  assign rdy2      = !v2_q | rdy3;
  assign rdy1      = !v1_q | rdy2;
  assign rdy0      = !v0_q | rdy1;
  assign in_ready  = rdy0;
  assign Out       = d3_q;
  assign out_valid = v3_q;
  assign occ       = {2'b0, v0_q} + {2'b0, v1_q} + {2'b0, v2_q} + {2'b0, v3_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v0_q, v1_q, v2_q, v3_q} <= '0;
      {d0_q, d1_q, d2_q, d3_q} <= '0;
      {c0_q, c1_q, c2_q}       <= '0;
      {op0_q, op1_q, op2_q}    <= '0;
      {f0_q, f1_q, f2_q}       <= '0;
    end else begin
      if (rdy0) begin
        v0_q  <= in_valid;
        d0_q  <= d0_d;
        c0_q  <= Cnt[3:1];
        op0_q <= Op;
        f0_q  <= In[15];
      end
      if (rdy1) begin
        v1_q  <= v0_q;
        d1_q  <= d1_d;
        c1_q  <= c0_q[3:2];
        op1_q <= op0_q;
        f1_q  <= f0_q;
      end
      if (rdy2) begin
        v2_q  <= v1_q;
        d2_q  <= d2_d;
        c2_q  <= c1_q[3];
        op2_q <= op1_q;
        f2_q  <= f1_q;
      end
      if (rdy3) begin
        v3_q <= v2_q;
        d3_q <= d3_d;
      end
    end
  end
endmodule

// File: tb/tb_shift_right_pipe.sv
// tb_shift_right_pipe: directed and random checks of shift_right_pipe against a queue scoreboard
module tb_shift_right_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] In = '0;
  logic [3:0]  Cnt = '0;
  logic [1:0]  Op = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] Out;
  logic        out_valid;
  logic        out_ready = 1;
  logic [2:0]  occ;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  logic [15:0] sb[$];

  shift_right_pipe dut (
    .clk(clk), .rst_n(rst_n), .In(In), .Cnt(Cnt), .Op(Op),
    .in_valid(in_valid), .in_ready(in_ready), .Out(Out),
    .out_valid(out_valid), .out_ready(out_ready), .occ(occ)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] c, input logic [1:0] op);
    logic [31:0] r;
    logic signed [15:0] s;
    r = {a, a} >> c;
    s = $signed(a) >>> c;
    if (op == 2'b00) return a;
    if (op == 2'b10) return r[15:0];
    if (op == 2'b01) return s;
    return a >> c;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL extra_output: observed %h expected none", Out);
      end else chk("sb_out", Out, sb.pop_front());
    end
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(model(In, Cnt, Op));
      n_acc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic one(input string tag, input logic [15:0] a, input logic [3:0] c,
                     input logic [1:0] op, input logic [15:0] exp);
    In = a; Cnt = c; Op = op; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_early"}, 16'(out_valid), 16'd0);
    end
    @(negedge clk);
    chk({tag, "_valid"}, 16'(out_valid), 16'd1);
    chk(tag, Out, exp);
    @(posedge clk); #1;
  endtask

  logic [15:0] bp_in[5];
  int idx;
  logic acc;
  int cyc;

  initial begin
    #3;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out", Out, 16'h0000);
    chk("rst_occ", 16'(occ), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    #9 rst_n = 1;
    @(posedge clk); #1;

    one("rot1", 16'h8001, 4'd1, 2'b10, 16'hC000);
    one("rot8", 16'h1234, 4'd8, 2'b10, 16'h3412);
    one("lsr4", 16'h8001, 4'd4, 2'b11, 16'h0800);
    one("asr15_neg", 16'h8000, 4'd15, 2'b01, 16'hFFFF);
    one("asr15_pos", 16'h7FFF, 4'd15, 2'b01, 16'h0000);
    one("pass", 16'hABCD, 4'd9, 2'b00, 16'hABCD);
    one("lsr15", 16'h8000, 4'd15, 2'b11, 16'h0001);
    one("rot15", 16'hC001, 4'd15, 2'b10, 16'h8003);
    one("cnt0", 16'h5A5A, 4'd0, 2'b01, 16'h5A5A);

    for (int i = 0; i < 21; i++) begin
      in_valid = i < 16; In = 16'h8000; Cnt = 4'(i); Op = 2'b11;
      @(negedge clk);
      if (i < 16) chk("stream_in_ready", 16'(in_ready), 16'd1);
      if (i >= 4 && i < 20) begin
        chk("stream_valid", 16'(out_valid), 16'd1);
        chk("stream_out", Out, 16'h8000 >> (i - 4));
      end
      if (i == 20) chk("stream_done", 16'(out_valid), 16'd0);
      @(posedge clk); #1;
    end
    in_valid = 0;

    bp_in = '{16'h1111, 16'h2222, 16'h4444, 16'h8888, 16'hF00F};
    out_ready = 0; idx = 0;
    repeat (6) begin
      In = bp_in[idx]; Cnt = 4'd4; Op = 2'b10; in_valid = 1;
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    @(negedge clk);
    chk("bp_accepted", 16'(idx), 16'd4);
    chk("bp_occ", 16'(occ), 16'd4);
    chk("bp_in_ready", 16'(in_ready), 16'd0);
    chk("bp_hold", Out, model(bp_in[0], 4'd4, 2'b10));
    @(posedge clk); #1;
    out_ready = 1;
    #1 chk("bp_ready_comb", 16'(in_ready), 16'd1);
    @(posedge clk); #1 out_ready = 0; in_valid = 0;
    @(negedge clk);
    chk("bp_occ_after", 16'(occ), 16'd4);
    chk("bp_next", Out, model(bp_in[1], 4'd4, 2'b10));
    chk("bp_sb_left", 16'(sb.size()), 16'd4);
    @(posedge clk); #1 out_ready = 1;
    repeat (6) @(posedge clk);
    #1 chk("bp_drain", 16'(sb.size()), 16'd0);

    for (int i = 0; i < 3; i++) begin
      In = 16'h0F0F + 16'(i); Cnt = 4'(i + 1); Op = 2'b11; in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_occ", 16'(occ), 16'd0);
    chk("mid_rst_out", Out, 16'h0000);
    chk("mid_rst_ready", 16'(in_ready), 16'd1);
    sb.delete();
    #10 rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_idle", 16'(out_valid), 16'd0);
    end
    @(posedge clk); #1;

    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 40000) begin
      In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_count_reached", 16'(n_acc >= 10000), 16'd1);
    in_valid = 0; out_ready = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("rand_drain_occ", 16'(occ), 16'd0);
    chk("rand_drain_sb", 16'(sb.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
